alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 12-bit combinational ALU.
- Generic WIDTH; valid/ready handshake on both input and output.
- Registered result and flag outputs; multi-cycle shift-add multiply.
- Sits between operand source and result sink; one operation in flight at a time.

Parameters:
- WIDTH, 12, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  4  opcode.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  sink accepts the result.
- result  output  WIDTH  registered result.
- agrtb, altb, aeqb  output  1 each  unsigned compare of the accepted a and b.
- carry  output  1  carry/borrow/multiply-high-nonzero.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow (add, sub, inc, dec only; else 0).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_valid=0; all result/flag outputs 0.
  - Any in-flight multiply is discarded.
- Accept rule:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - The transfer happens when in_valid && in_ready.
  - A result pop and a new accept may occur in the same cycle.
- Opcodes:
  - 0 add; 1 sub (a-b); 2 and; 3 or; 4 xor; 5 nand; 6 nor; 7 xnor.
  - 8 not a; 9 shl a; 10 shr (logical) a; 11 sra a; 12 rotl a.
  - 13 inc a; 14 dec a; 15 mul (low WIDTH bits of a*b, unsigned).
- Arithmetic:
  - All results are truncated to WIDTH bits.
  - add/inc: carry = bit WIDTH of the sum.
  - sub/dec: carry = borrow (1 when the unsigned minuend < subtrahend).
  - Logic ops and rotl: carry=0.
- Shifts (sh = b[SHW-1:0]):
  - sh >= WIDTH: shl/shr give 0, sra gives replicated a[WIDTH-1].
  - rotl uses sh mod WIDTH.
  - Last bit shifted out goes to carry (0 for sh=0).
- Compare flags: computed from the accepted a and b for every opcode, and registered with the result.
- States:
  - IDLE, accept of op 0-14: load result/flags; out_valid=1 next cycle (latency 1); stay IDLE.
  - IDLE, accept of op 15: latch a, b, compare flags; go to MUL; counter=0; accumulator=0.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the last step, load result = accumulator[WIDTH-1:0] and carry = |accumulator[2*WIDTH-1:WIDTH]. Set out_valid=1 and return to IDLE. Multiply latency is WIDTH+1 cycles from accept to out_valid.
  - In MUL, in_ready=0.
- Output hold:
  - While out_valid && !out_ready, result and all flags hold stable.
  - out_valid drops the cycle after a pop unless a new single-cycle op was accepted at the pop.
- Inputs a, b, sel are sampled only at accept; changes at other times have no effect.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined: add, sub, inc, dec saturate in two's complement on signed overflow:
  - positive overflow -> 0111..1;
  - negative overflow -> 1000..0;
  - ovf=1;
  - carry is computed as without saturation.
- Undefined: wrap-around result; ovf still reports overflow.

Test Plan:
- add a=0xFFF b=0x001 -> result 0x000, carry=1, zero=1, agrtb=1, ovf=0, out_valid 1 cycle after accept.
- sub a=0x005 b=0x007 -> result 0xFFE, carry=1, altb=1, zero=0; sra a=0x800 sh=15 -> result 0xFFF.
- mul a=0x040 b=0x040 -> out_valid exactly 13 cycles after accept, result 0x000, carry=1, zero=1. in_ready=0 throughout; mul 0x003*0x005 -> 0x00F, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after add 0x123+0x111 -> result 0x234 stable, in_ready=0. Raise out_ready with in_valid=1 (sel=2) -> pop and accept in the same cycle; next result = a&b.
- Reset: drive rst_n=0 at MUL step 6 -> next cycle out_valid=0, outputs 0, in_ready=1; no stale mul result appears.
- add a=0x7FF b=0x001 -> with ALU_SATURATE_EN result 0x7FF, ovf=1; without it result 0x800, ovf=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshake and shift-add multiply (ALU_SATURATE_EN enables saturating add/sub/inc/dec)
module alu_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             agrtb,
    output logic             altb,
    output logic             aeqb,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc, mcand, acc_n;
    logic [WIDTH-1:0]   mplier, op2, ar, r_c, rol;
    logic [WIDTH:0]     s, shl_e, shr_e, sra_e;
    logic [SHW-1:0]     cnt, sh, rot;
    logic               is_sub, arith, ovf_c, c_c, v_c, accept;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_n    = acc + (mplier[0] ? mcand : '0);

    // single-cycle datapath: result, carry and overflow for opcodes 0-14
    always_comb begin
        sh     = b[SHW-1:0];
        rot    = SHW'(int'(sh) % WIDTH);
        shl_e  = {1'b0, a} << sh;
        shr_e  = {a, 1'b0} >> sh;
        sra_e  = $signed({a, 1'b0}) >>> sh;
        rol    = (a << rot) | (a >> (WIDTH - int'(rot)));
        is_sub = (sel == 4'd1) || (sel == 4'd14);
        arith  = (sel == 4'd0) || (sel == 4'd1) || (sel == 4'd13) || (sel == 4'd14);
        op2    = (sel == 4'd13 || sel == 4'd14) ? WIDTH'(1) : b;
        s      = is_sub ? {1'b0, a} - {1'b0, op2} : {1'b0, a} + {1'b0, op2};
        ovf_c  = (is_sub ? (a[WIDTH-1] != op2[WIDTH-1]) : (a[WIDTH-1] == op2[WIDTH-1]))
                 && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SATURATE_EN
        ar     = ovf_c ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : s[WIDTH-1:0];
`else
        ar     = s[WIDTH-1:0];
`endif
        v_c    = arith ? ovf_c : 1'b0;
        r_c    = '0;
        c_c    = 1'b0;
        case (sel)
            4'd0, 4'd1, 4'd13, 4'd14: begin r_c = ar; c_c = s[WIDTH]; end
            4'd2:    r_c = a & b;
            4'd3:    r_c = a | b;
            4'd4:    r_c = a ^ b;
            4'd5:    r_c = ~(a & b);
            4'd6:    r_c = ~(a | b);
            4'd7:    r_c = ~(a ^ b);
            4'd8:    r_c = ~a;
            4'd9:    begin r_c = shl_e[WIDTH-1:0]; c_c = shl_e[WIDTH]; end
            4'd10:   begin r_c = shr_e[WIDTH:1]; c_c = shr_e[0]; end
            4'd11:   begin r_c = sra_e[WIDTH:1]; c_c = sra_e[0]; end
            4'd12:   r_c = rol;
            default: r_c = '0;
        endcase
    end

    // control, output registers and the shift-add multiplier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            {agrtb, altb, aeqb, carry, zero, ovf} <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    agrtb <= a > b;
                    altb  <= a < b;
                    aeqb  <= a == b;
                    if (sel == 4'd15) begin
                        state  <= MUL;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        result    <= r_c;
                        carry     <= c_c;
                        ovf       <= v_c;
                        zero      <= r_c == '0;
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_n;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == SHW'(WIDTH - 1)) begin
                    result    <= acc_n[WIDTH-1:0];
                    carry     <= |acc_n[2*WIDTH-1:WIDTH];
                    zero      <= acc_n[WIDTH-1:0] == '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table, corner-sequence and randomized checks of alu_pipe against an arithmetic model
module tb_alu_pipe;
    localparam int W = 12;
    localparam int M = 1 << W;

    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [W-1:0] a = 0, b = 0;
    logic [3:0]   sel = 0;
    logic         in_ready, out_valid, agrtb, altb, aeqb, carry, zero, ovf;
    logic [W-1:0] result;

    int total = 0, bad = 0;

    typedef struct {int a; int b; int sel; int res; int c; int z; int v; int cmp; int lat;} vec_t;
    typedef struct {int res; int c; int z; int v; int cmp;} exp_t;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .agrtb(agrtb), .altb(altb), .aeqb(aeqb),
        .carry(carry), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int xa, input int xb, input int xs);
        exp_t e;
        int sh, sa, op, so, t, st, r;
        bit neg;
        e = '{0, 0, 0, 0, 0};
        sh = xb % 16;
        sa = xa >= M / 2 ? xa - M : xa;
        case (xs)
            0, 1, 13, 14: begin
                op = xs >= 13 ? 1 : xb;
                so = op >= M / 2 ? op - M : op;
                neg = (xs == 1 || xs == 14);
                t = neg ? xa - op : xa + op;
                st = neg ? sa - so : sa + so;
                e.res = (t + M) % M;
                e.c = neg ? int'(xa < op) : int'(t >= M);
                e.v = int'(st > M / 2 - 1 || st < -M / 2);
`ifdef ALU_SATURATE_EN
                if (e.v != 0) e.res = st > 0 ? M / 2 - 1 : M / 2;
`endif
            end
            2: e.res = xa & xb;
            3: e.res = xa | xb;
            4: e.res = xa ^ xb;
            5: e.res = ~(xa & xb) & (M - 1);
            6: e.res = ~(xa | xb) & (M - 1);
            7: e.res = ~(xa ^ xb) & (M - 1);
            8: e.res = ~xa & (M - 1);
            9: begin
                e.res = sh >= W ? 0 : (xa << sh) % M;
                e.c = (sh == 0 || sh > W) ? 0 : (xa >> (W - sh)) & 1;
            end
            10: begin
                e.res = sh >= W ? 0 : xa >> sh;
                e.c = (sh == 0 || sh > W) ? 0 : (xa >> (sh - 1)) & 1;
            end
            11: begin
                e.res = ((sa >>> (sh >= W ? W - 1 : sh)) + M) % M;
                e.c = sh == 0 ? 0 : (xa >> ((sh > W ? W : sh) - 1)) & 1;
            end
            12: begin
                r = sh % W;
                e.res = ((xa << r) | (xa >> (W - r))) % M;
            end
            default: begin
                t = xa * xb;
                e.res = t % M;
                e.c = int'(t >= M);
            end
        endcase
        e.z = int'(e.res == 0);
        e.cmp = (xa > xb ? 4 : 0) + (xa < xb ? 2 : 0) + (xa == xb ? 1 : 0);
        return e;
    endfunction

    task automatic run(input int xa, input int xb, input int xs, input string tag,
                       input int eres, input int ec, input int ez, input int ev,
                       input int ecmp, input int elat);
        int lat;
        bit busy_ok;
        @(negedge clk);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        a = W'(xa);
        b = W'(xb);
        sel = 4'(xs);
        in_valid = 1;
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        busy_ok = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        if (xs == 15) chk({tag, " busy"}, int'(busy_ok), 1);
        chk({tag, " result"}, int'(result), eres);
        chk({tag, " carry"}, int'(carry), ec);
        chk({tag, " zero"}, int'(zero), ez);
        chk({tag, " ovf"}, int'(ovf), ev);
        chk({tag, " cmp"}, int'({agrtb, altb, aeqb}), ecmp);
    endtask

    vec_t tbl[10];
    exp_t e;
    int ra, rb, rs;
    bit stale;

    initial begin
`ifdef ALU_SATURATE_EN
        tbl[0] = '{'h7FF, 'h001, 0, 'h7FF, 0, 0, 1, 4, 1};
`else
        tbl[0] = '{'h7FF, 'h001, 0, 'h800, 0, 0, 1, 4, 1};
`endif
        tbl[1] = '{'hFFF, 'h001, 0, 'h000, 1, 1, 0, 4, 1};
        tbl[2] = '{'h005, 'h007, 1, 'hFFE, 1, 0, 0, 2, 1};
        tbl[3] = '{'h800, 'h00F, 11, 'hFFF, 1, 0, 0, 4, 1};
        tbl[4] = '{'h040, 'h040, 15, 'h000, 1, 1, 0, 1, 13};
        tbl[5] = '{'h003, 'h005, 15, 'h00F, 0, 0, 0, 2, 13};
        tbl[6] = '{'h801, 'h001, 9, 'h002, 1, 0, 0, 4, 1};
        tbl[7] = '{'h801, 'h00D, 12, 'h003, 0, 0, 0, 4, 1};
        tbl[8] = '{'h000, 'h000, 14, 'hFFF, 1, 0, 0, 1, 1};
        tbl[9] = '{'hFFF, 'hFFF, 5, 'h000, 0, 1, 0, 1, 1};

        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++)
            run(tbl[i].a, tbl[i].b, tbl[i].sel, $sformatf("vec%0d", i),
                tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].v, tbl[i].cmp, tbl[i].lat);

        @(negedge clk);
        a = 'h123; b = 'h111; sel = 0; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        chk("bp valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold result", int'(result), 'h234);
            chk("bp hold valid", int'(out_valid), 1);
            chk("bp in_ready low", int'(in_ready), 0);
        end
        a = 'hF0F; b = 'h0FF; sel = 2; in_valid = 1; out_ready = 1;
        #1 chk("bp in_ready at pop", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 0;
        chk("bp next valid", int'(out_valid), 1);
        chk("bp next result", int'(result), 'h00F);

        @(negedge clk);
        a = 'h0FF; b = 'h0FF; sel = 15; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("mulrst out_valid", int'(out_valid), 0);
        chk("mulrst result", int'(result), 0);
        chk("mulrst flags", int'({carry, zero, ovf, agrtb, altb, aeqb}), 0);
        chk("mulrst in_ready", int'(in_ready), 1);
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        chk("mulrst stale", int'(stale), 0);

        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(M - 1));
            rb = int'($urandom_range(M - 1));
            rs = int'($urandom_range(15));
            e = model(ra, rb, rs);
            run(ra, rb, rs, $sformatf("rnd%0d op%0d", i, rs),
                e.res, e.c, e.z, e.v, e.cmp, rs == 15 ? W + 1 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
